// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage feeding the add/sub executor. Holds a loadable
//   program memory and streams words 0..end_addr in order through a
//   prefetch FIFO with a valid/ready handshake.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   load_en/addr/data     : program memory write port (IDLE only)
//   start, end_addr       : begin a run over addresses 0..end_addr (IDLE only)
//   abort                 : flush back to IDLE, no done pulse
//   instr_out/valid/ready : FIFO head word and handshake to the executor
//   pc_out                : next address to be issued
//   busy                  : run in progress (FETCH or DRAIN)
//   done                  : one-cycle pulse after the last word is accepted
module instr_fetch_unit #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] end_q;
  logic              inflight;
  logic [31:0]       rd_data;

  logic [31:0]       mem      [0:(1<<ADDR_W)-1];
  logic [31:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occupancy;

  logic issue;
  logic flush;
  logic push;
  logic pop;

  // Words already buffered plus the read still in flight; gating issue on
  // this keeps the FIFO from ever overflowing.
  assign occupancy   = count + CW'(inflight);
  assign flush       = abort && (state != IDLE);
  assign push        = inflight;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = instr_valid ? fifo_mem[rd_ptr] : '0;
  assign pc_out      = pc;
  assign busy        = (state != IDLE);

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        if (occupancy < DEPTH_C) begin
          issue = 1'b1;
          if (pc == end_q) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && (count == '0)) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      issue   = 1'b0;
      done    = 1'b0;
    end
    if (reset) done = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      end_q    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        pc       <= '0;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if ((state == IDLE) && start) begin
          end_q <= end_addr;
          pc    <= '0;
        end
        if (issue) pc <= pc + ADDR_W'(1);
        inflight <= issue;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage without reset: program memory, read register and FIFO slots.
  always_ff @(posedge clk) begin
    if (load_en && (state == IDLE)) mem[load_addr] <= load_data;
    if (issue) rd_data <= mem[pc];
    if (push) fifo_mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic [ADDR_W-1:0] end_addr;
  logic              abort;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [31:0] prog [16];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .end_addr(end_addr), .abort(abort),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] ea);
    end_addr = ea; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int got;
    bit seen;

    prog[0] = 32'h88000302; prog[1] = 32'h89000503;
    prog[2] = 32'h8A000007; prog[3] = 32'h00000204;
    for (int k = 4; k < 16; k++) prog[k] = 32'hA5000000 + 32'(k);

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; end_addr = '0; abort = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_out",   instr_out,   0);
    chk("rst_busy",  busy,        0);
    chk("rst_done",  done,        0);
    chk("rst_pc",    pc_out,      0);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) load_word(4'(k), prog[k]);

    // Test 1: full-rate 4-word run
    instr_ready = 1'b1;
    do_start(4'd3);
    chk("t1_busy", busy, 1);
    chk("t1_valid_n0", instr_valid, 0);
    tick();
    chk("t1_valid_n1", instr_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", instr_valid, 1);
      chk("t1_word", instr_out, prog[k]);
      chk("t1_nodone", done, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_empty", instr_valid, 0);
    tick();
    chk("t1_done_once", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_pc_end", pc_out, 4);

    // Test 2: backpressure fills FIFO
    instr_ready = 1'b0;
    do_start(4'd3);
    tick(); tick();
    chk("t2_head", instr_out, 32'h88000302);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_valid_hold", instr_valid, 1);
      chk("t2_stable", instr_out, 32'h88000302);
    end
    chk("t2_pc_stop", pc_out, 4);
    chk("t2_busy", busy, 1);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_word", instr_out, prog[k]);
      tick();
    end
    chk("t2_done", done, 1);
    chk("t2_empty", instr_valid, 0);
    tick();
    chk("t2_idle", busy, 0);

    // Test 3: toggled ready, 16 words
    do_start(4'd15);
    got = 0; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      instr_ready = (c % 2 == 0);
      if (done) begin
        seen = 1;
        chk("t3_done_empty", instr_valid, 0);
      end else begin
        if (instr_valid && instr_ready) begin
          chk("t3_word", instr_out, prog[got & 15]);
          got++;
        end
        tick();
      end
    end
    chk("t3_seen_done", 32'(seen), 1);
    chk("t3_count", got, 16);
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_pc_wrap", pc_out, 0);

    // Test 4: single-word runs
    instr_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_start(4'd0);
      tick();
      chk("t4_pc", pc_out, 1);
      chk("t4_valid_n1", instr_valid, 0);
      tick();
      chk("t4_valid", instr_valid, 1);
      chk("t4_word", instr_out, prog[0]);
      tick();
      chk("t4_done", done, 1);
      chk("t4_empty", instr_valid, 0);
      tick();
      chk("t4_idle", busy, 0);
      chk("t4_nodone", done, 0);
    end

    // Test 5: abort mid-run, then restart
    do_start(4'd15);
    tick(); tick(); tick();
    chk("t5_pre_valid", instr_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid", instr_valid, 0);
    chk("t5_out", instr_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pc", pc_out, 0);
    chk("t5_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_quiet_valid", instr_valid, 0);
      chk("t5_quiet_done", done, 0);
    end
    do_start(4'd1);
    tick(); tick();
    chk("t5_re_word0", instr_out, prog[0]);
    tick();
    chk("t5_re_word1", instr_out, prog[1]);
    tick();
    chk("t5_re_done", done, 1);
    tick();

    // Test 6: load during FETCH ignored, then reset mid-run
    instr_ready = 1'b0;
    do_start(4'd3);
    tick();
    load_en = 1'b1; load_addr = 4'd2; load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    tick(); tick(); tick();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_word", instr_out, prog[k]);
      tick();
    end
    chk("t6_done", done, 1);
    tick();
    do_start(4'd15);
    tick(); tick(); tick(); tick();
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_out", instr_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pc", pc_out, 0);
    reset = 1'b0;
    tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_valid", instr_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
